// File: rtl/data_read_axi_read.sv
// AXI-lite read-channel slave for the data_read core: serves CR/SR/DR/CNT reads,
// keeps the sticky DONE/OVF flags and pops the capture FIFO on DR reads.
module data_read_axi_read (
  input  logic        S_AXI_ACLK,
  input  logic        S_AXI_ARESETN,
  input  logic [31:0] S_AXI_ARADDR,
  input  logic        S_AXI_ARVALID,
  output logic        S_AXI_ARREADY,
  output logic [31:0] S_AXI_RDATA,
  output logic [1:0]  S_AXI_RRESP,
  output logic        S_AXI_RVALID,
  input  logic        S_AXI_RREADY,
  input  logic        sr_busy,
  input  logic        sr_done_set,
  input  logic        sr_ovf_set,
  input  logic        fifo_empty,
  input  logic [31:0] fifo_dout,
  input  logic [15:0] fifo_count,
  output logic        fifo_rd_en,
  output logic [1:0]  dbg_state
);

  localparam logic [5:0] OFF_CR  = 6'h00;
  localparam logic [5:0] OFF_SR  = 6'h01;
  localparam logic [5:0] OFF_DR  = 6'h02;
  localparam logic [5:0] OFF_CNT = 6'h03;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ADDR = 2'd1,
    S_DATA = 2'd2
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [5:0]  offset;
  logic [31:0] dec_data;
  logic [1:0]  dec_resp;
  logic        dec_pop;
  logic        flag_done;
  logic        flag_ovf;
  logic        sr_clr;

  logic unused_addr;
  assign unused_addr = &{1'b0, S_AXI_ARADDR[31:8], S_AXI_ARADDR[1:0]};

  assign offset    = S_AXI_ARADDR[7:2];
  assign dbg_state = state;

  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      state <= S_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (S_AXI_ARVALID) state_nxt = S_ADDR;
      S_ADDR:  state_nxt = S_DATA;
      S_DATA:  if (S_AXI_RREADY) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Outputs decode from state only, so ARREADY never follows ARVALID combinationally.
  always_comb begin
    S_AXI_ARREADY = (state == S_ADDR);
    S_AXI_RVALID  = (state == S_DATA);
    fifo_rd_en    = (state == S_ADDR) && dec_pop;
  end

  always_comb begin
    dec_data = '0;
    dec_resp = RESP_OKAY;
    dec_pop  = 1'b0;
    case (offset)
      OFF_CR:  dec_data = '0;
      OFF_SR:  dec_data = {28'd0, fifo_empty, flag_ovf, flag_done, sr_busy};
      OFF_DR: begin
        if (fifo_empty) begin
          dec_resp = RESP_SLVERR;
        end else begin
          dec_data = fifo_dout;
          dec_pop  = 1'b1;
        end
      end
      OFF_CNT: dec_data = {16'd0, fifo_count};
      default: dec_data = '0;
    endcase
  end

  // Response is captured once on the S_ADDR edge and held through any RREADY stall.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      S_AXI_RDATA <= '0;
      S_AXI_RRESP <= RESP_OKAY;
    end else if (state == S_ADDR) begin
      S_AXI_RDATA <= dec_data;
      S_AXI_RRESP <= dec_resp;
    end
  end

  assign sr_clr = (state == S_ADDR) && (offset == OFF_SR);

  // A set pulse coinciding with the clear-on-read edge wins.
  always_ff @(posedge S_AXI_ACLK or negedge S_AXI_ARESETN) begin
    if (!S_AXI_ARESETN) begin
      flag_done <= 1'b0;
      flag_ovf  <= 1'b0;
    end else begin
      if (sr_done_set)  flag_done <= 1'b1;
      else if (sr_clr)  flag_done <= 1'b0;
      if (sr_ovf_set)   flag_ovf  <= 1'b1;
      else if (sr_clr)  flag_ovf  <= 1'b0;
    end
  end

endmodule
